timer_compare_channel: RTL and testbench
========================================

Name: timer_compare_channel

Overview:
- Compare/PWM channel sitting directly downstream of the up/down timer counter.
- Consumes the counter's count value and its enable, mode, min and max controls.
- Produces a registered PWM/toggle output, a match interrupt flag and a period-update flag.
- Compare value is double-buffered (preload → active) so duty-cycle changes take effect glitch-free at the counter wrap.

Parameters:
- COUNTER_BIT_WIDTH, 8, width of count, min, max and compare values; must equal the driving counter's width.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  same advance strobe that drives the counter.
- count_mode  input  1  0 = up, 1 = down; same signal as the counter.
- count  input  COUNTER_BIT_WIDTH  current counter value.
- count_min  input  COUNTER_BIT_WIDTH  counter lower bound.
- count_max  input  COUNTER_BIT_WIDTH  counter upper bound.
- cmp_wr_en  input  1  single-cycle compare write strobe.
- cmp_wr_data  input  COUNTER_BIT_WIDTH  compare write value.
- preload_en  input  1  1 = buffered compare update, 0 = immediate update.
- out_mode  input  2  00 force-inactive, 01 toggle-on-match, 10 PWM1, 11 PWM2.
- out_pol  input  1  1 = invert output.
- irq_en  input  1  enables setting of match_flag.
- irq_clr  input  1  single-cycle clear for match_flag and upd_flag.
- cmp_active  output  COUNTER_BIT_WIDTH  compare value currently in use.
- pwm_out  output  1  registered channel output.
- match_flag  output  1  sticky match interrupt.
- upd_flag  output  1  sticky period-update (wrap) flag.

Behaviour:
- Reset (async, rst=0): cmp_preload=0, cmp_active=0, toggle_q=0, pwm_out=0, match_flag=0, upd_flag=0. All state is held while rst=0.
- match_event (combinational) = enable && (count == cmp_active). It fires once per pass when enable is continuously high. No event while enable is low, even if count equals cmp_active.
- update_event (combinational) = enable && (up ? count >= count_max : count <= count_min). This is exactly the counter's wrap condition.
- Compare write, preload_en=0: on cmp_wr_en, both cmp_preload and cmp_active take cmp_wr_data at the next edge.
- Compare write, preload_en=1: on cmp_wr_en, cmp_preload takes cmp_wr_data. cmp_active <= cmp_preload on update_event.
- Simultaneous cmp_wr_en and update_event with preload_en=1: cmp_active takes the OLD preload value; the new value applies at the following update_event.
- Toggle state: toggle_q inverts on match_event. It is reset to 0 whenever out_mode changes away from 01.
- Raw output:
  - 00 → 0
  - 01 → toggle_q
  - 10 → (count < cmp_active)
  - 11 → !(count < cmp_active)
- pwm_out <= raw ^ out_pol; 1-clock latency from count/cmp_active.
- PWM boundary cases:
  - cmp_active <= count_min gives 0% duty in PWM1.
  - cmp_active > count_max gives 100% duty in PWM1.
  - No glitch at wrap.
- match_flag: set on match_event && irq_en; cleared by irq_clr. Set wins over a simultaneous clear.
- upd_flag: set on update_event; cleared by irq_clr. Set wins over a simultaneous clear.
- count_mode change mid-period: comparisons use the current inputs only; no internal recovery state.
- Widths: all comparisons are unsigned, COUNTER_BIT_WIDTH bits. No arithmetic overflow is possible.

Decomposition:
- Shared timer package holds:
  - MODE_UP = 1'b0 and MODE_DOWN = 1'b1, reused by the counter;
  - OUT_FORCE = 2'b00, OUT_TOGGLE = 2'b01, OUT_PWM1 = 2'b10, OUT_PWM2 = 2'b11.
- One natural sub-module: timer_sticky_flag (set/clear with set priority, async active-low reset), instantiated twice.

Test Plan:
- Reset with cmp_wr_data=5 pending → all outputs 0; cmp_active=0 after rst release.
- Up mode, min=0, max=9, enable=1, preload_en=0, write 4, PWM1, out_pol=0 → pwm_out high for count 0..3 (visible one clock later), low for 4..9; period 10 clocks, duty 40%.
- preload_en=1, write 7 mid-period at count=2 → cmp_active stays 4 until the cycle after count=9, then becomes 7. Also write at count=9 → active takes the old preload; the new value appears one period later.
- Toggle mode, cmp=3, down mode min=0, max=5 → pwm_out toggles one clock after each count=3 with enable, i.e. every 6 clocks; enable held low at count=3 → no toggle.
- irq_en=1, cmp=2 → match_flag sets after count=2. irq_clr asserted in the same cycle as the next match → flag stays 1. irq_clr alone → 0.
- Boundary: cmp=0 with min=0 in PWM1 → pwm_out constantly 0. cmp=10 with max=9 → constantly 1. out_pol=1 inverts both.

Source files
------------

// File: rtl/timer_compare_channel_pkg.sv
// Shared timer constants: count direction and compare output modes.
// Imported by the counter and by the compare channel.
package timer_compare_channel_pkg;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  localparam logic [1:0] OUT_FORCE  = 2'b00;
  localparam logic [1:0] OUT_TOGGLE = 2'b01;
  localparam logic [1:0] OUT_PWM1   = 2'b10;
  localparam logic [1:0] OUT_PWM2   = 2'b11;

  typedef struct packed {
    logic match_event;
    logic update_event;
  } cmp_events_t;

endpackage

// File: rtl/timer_compare_channel_if.sv
// Counter-to-compare-channel bundle.
// The master drives the counter view and controls; the slave is the channel.
interface timer_compare_channel_if #(
  parameter int W = 8
) ();

  logic         enable;
  logic         count_mode;
  logic [W-1:0] count;
  logic [W-1:0] count_min;
  logic [W-1:0] count_max;
  logic         cmp_wr_en;
  logic [W-1:0] cmp_wr_data;
  logic         preload_en;
  logic [1:0]   out_mode;
  logic         out_pol;
  logic         irq_en;
  logic         irq_clr;
  logic [W-1:0] cmp_active;
  logic         pwm_out;
  logic         match_flag;
  logic         upd_flag;

  modport master (
    output enable, count_mode, count,
    output count_min, count_max,
    output cmp_wr_en, cmp_wr_data, preload_en,
    output out_mode, out_pol,
    output irq_en, irq_clr,
    input  cmp_active, pwm_out,
    input  match_flag, upd_flag
  );

  modport slave (
    input  enable, count_mode, count,
    input  count_min, count_max,
    input  cmp_wr_en, cmp_wr_data, preload_en,
    input  out_mode, out_pol,
    input  irq_en, irq_clr,
    output cmp_active, pwm_out,
    output match_flag, upd_flag
  );

endinterface

// File: rtl/timer_compare_channel_flag.sv
// Sticky status flag: set has priority over a same-cycle clear.
// Async active-low reset.
module timer_sticky_flag (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  output logic flag
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      flag <= 1'b0;
    else if (set)
      flag <= 1'b1;
    else if (clr)
      flag <= 1'b0;
  end

endmodule

// File: rtl/timer_compare_channel.sv
// Compare/PWM channel behind the up/down counter.
// Double-buffered compare, registered output, sticky irq flags.
module timer_compare_channel
  import timer_compare_channel_pkg::*;
#(
  parameter int COUNTER_BIT_WIDTH = 8
) (
  input logic                    clk,
  input logic                    rst,
  timer_compare_channel_if.slave bus
);

  localparam int W = COUNTER_BIT_WIDTH;

  logic [W-1:0] cmp_preload;
  logic [W-1:0] cmp_active_q;
  logic         toggle_q;
  logic         toggle_d;
  logic         pwm_q;
  logic         raw;
  logic         below;
  logic         wrap_hit;
  cmp_events_t  ev;

  always_comb begin
    wrap_hit = (bus.count_mode == MODE_UP)
             ? (bus.count >= bus.count_max)
             : (bus.count <= bus.count_min);
    ev.match_event  = bus.enable
                    && (bus.count == cmp_active_q);
    ev.update_event = bus.enable && wrap_hit;
    below = bus.count < cmp_active_q;
  end

  // Toggle state only lives in toggle mode.
  always_comb begin
    toggle_d = toggle_q;
    if (bus.out_mode != OUT_TOGGLE)
      toggle_d = 1'b0;
    else if (ev.match_event)
      toggle_d = ~toggle_q;
  end

  always_comb begin
    raw = 1'b0;
    unique case (1'b1)
      (bus.out_mode == OUT_FORCE):  raw = 1'b0;
      (bus.out_mode == OUT_TOGGLE): raw = toggle_d;
      (bus.out_mode == OUT_PWM1):   raw = below;
      (bus.out_mode == OUT_PWM2):   raw = ~below;
      default:                      raw = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp_preload  <= '0;
      cmp_active_q <= '0;
    end else begin
      if (bus.cmp_wr_en)
        cmp_preload <= bus.cmp_wr_data;
      // Wrap-time transfer uses the old preload.
      if (bus.cmp_wr_en && !bus.preload_en)
        cmp_active_q <= bus.cmp_wr_data;
      else if (bus.preload_en && ev.update_event)
        cmp_active_q <= cmp_preload;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      toggle_q <= 1'b0;
      pwm_q    <= 1'b0;
    end else begin
      toggle_q <= toggle_d;
      pwm_q    <= raw ^ bus.out_pol;
    end
  end

  timer_sticky_flag u_match_flag (
    .clk  (clk),
    .rst  (rst),
    .set  (ev.match_event && bus.irq_en),
    .clr  (bus.irq_clr),
    .flag (bus.match_flag)
  );

  timer_sticky_flag u_upd_flag (
    .clk  (clk),
    .rst  (rst),
    .set  (ev.update_event),
    .clr  (bus.irq_clr),
    .flag (bus.upd_flag)
  );

  assign bus.cmp_active = cmp_active_q;
  assign bus.pwm_out    = pwm_q;

endmodule

// File: tb/tb_timer_compare_channel.sv
// Randomized bench for timer_compare_channel against a cycle model.
// Includes a free-running counter model that feeds the channel.
module tb_timer_compare_channel;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  timer_compare_channel_if #(.W(8)) bus ();

  timer_compare_channel #(
    .COUNTER_BIT_WIDTH(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  // reference state
  logic [7:0] m_pre, m_act, cnt;
  logic       m_tog, m_pwm, m_mf, m_uf;

  task automatic model_step();
    logic match, upd, nt, r;
    logic [7:0] act, pre;
    match = bus.enable && (cnt == m_act);
    if (bus.count_mode)
      upd = bus.enable && (cnt <= bus.count_min);
    else
      upd = bus.enable && (cnt >= bus.count_max);
    nt = (bus.out_mode != 2'd1) ? 1'b0 : (match ? !m_tog : m_tog);
    case (bus.out_mode)
      2'd0: r = 1'b0;
      2'd1: r = nt;
      2'd2: r = (cnt < m_act);
      default: r = !(cnt < m_act);
    endcase
    act = m_act;
    pre = m_pre;
    if (bus.cmp_wr_en) pre = bus.cmp_wr_data;
    if (bus.cmp_wr_en && !bus.preload_en) act = bus.cmp_wr_data;
    else if (bus.preload_en && upd) act = m_pre;
    m_pre = pre;
    m_act = act;
    m_tog = nt;
    m_pwm = r ^ bus.out_pol;
    if (match && bus.irq_en) m_mf = 1'b1;
    else if (bus.irq_clr) m_mf = 1'b0;
    if (upd) m_uf = 1'b1;
    else if (bus.irq_clr) m_uf = 1'b0;
    // counter advances with the same strobe
    if (bus.enable) begin
      if (bus.count_mode)
        cnt = (cnt <= bus.count_min) ? bus.count_max : cnt - 8'd1;
      else
        cnt = (cnt >= bus.count_max) ? bus.count_min : cnt + 8'd1;
    end
  endtask

  task automatic check_all(input string ph);
    check({ph, " cmp_active"}, bus.cmp_active, m_act);
    check({ph, " pwm_out"}, {7'd0, bus.pwm_out}, {7'd0, m_pwm});
    check({ph, " match_flag"}, {7'd0, bus.match_flag}, {7'd0, m_mf});
    check({ph, " upd_flag"}, {7'd0, bus.upd_flag}, {7'd0, m_uf});
  endtask

  initial begin
    logic skipped;
    string ph;
    bus.enable      = 1'b0;
    bus.count_mode  = 1'b0;
    bus.count       = 8'd0;
    bus.count_min   = 8'd0;
    bus.count_max   = 8'd9;
    bus.cmp_wr_en   = 1'b1;
    bus.cmp_wr_data = 8'd5;
    bus.preload_en  = 1'b0;
    bus.out_mode    = 2'd2;
    bus.out_pol     = 1'b0;
    bus.irq_en      = 1'b1;
    bus.irq_clr     = 1'b0;
    m_pre = 0; m_act = 0; m_tog = 0;
    m_pwm = 0; m_mf = 0; m_uf = 0;
    cnt = 0;
    repeat (3) @(negedge clk);
    check_all("reset");
    bus.cmp_wr_en = 1'b0;
    rst = 1'b1;

    for (int p = 0; p < 40; p++) begin
      skipped = 1'b0;
      ph = $sformatf("ph%0d", p);
      bus.irq_en  = 1'b1;
      bus.out_pol = (p == 5 || p == 6);
      case (p)
        0, 1: begin
          bus.count_min = 0; bus.count_max = 9;
          bus.count_mode = 0; bus.out_mode = 2'd2;
          bus.preload_en = (p == 1);
        end
        2: begin
          bus.count_min = 0; bus.count_max = 5;
          bus.count_mode = 1; bus.out_mode = 2'd1;
          bus.preload_en = 0;
        end
        3, 4, 5, 6: begin
          bus.count_min = 0; bus.count_max = 9;
          bus.count_mode = p[0]; bus.out_mode = 2'd2;
          bus.preload_en = 0;
        end
        default: begin
          bus.count_min = 8'($urandom_range(0, 7));
          bus.count_max = bus.count_min
                        + 8'($urandom_range(0, 11));
          bus.count_mode = 1'($urandom);
          bus.out_mode = 2'($urandom);
          bus.preload_en = 1'($urandom);
          bus.out_pol = 1'($urandom);
        end
      endcase
      cnt = bus.count_min;
      for (int c = 0; c < 40; c++) begin
        bus.count   = cnt;
        bus.enable  = 1'b1;
        bus.cmp_wr_en = 1'b0;
        bus.irq_clr = (c % 7 == 6);
        case (p)
          0: if (c == 0) begin
            bus.cmp_wr_en = 1; bus.cmp_wr_data = 4;
          end
          1: if (c > 0 && (cnt == 2 || cnt == 9)) begin
            bus.cmp_wr_en = 1;
            bus.cmp_wr_data = (cnt == 2) ? 8'd7 : 8'($urandom_range(0, 9));
          end
          2: begin
            if (c == 0) begin
              bus.cmp_wr_en = 1; bus.cmp_wr_data = 3;
            end
            if (c > 20 && cnt == 3 && !skipped) begin
              bus.enable = 0; skipped = 1;
            end
          end
          3, 4, 5, 6: if (c == 0) begin
            bus.cmp_wr_en = 1;
            bus.cmp_wr_data = (p % 2 == 1) ? 8'd0 : 8'd10;
          end
          default: begin
            bus.enable = ($urandom_range(0, 7) != 0);
            bus.cmp_wr_en = ($urandom_range(0, 5) == 0);
            bus.cmp_wr_data = 8'($urandom_range(0,
                                int'(bus.count_max) + 2));
            bus.irq_en = 1'($urandom);
            bus.irq_clr = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0)
              bus.out_mode = 2'($urandom);
            if ($urandom_range(0, 29) == 0)
              bus.count_mode = ~bus.count_mode;
            if ($urandom_range(0, 29) == 0)
              bus.preload_en = ~bus.preload_en;
          end
        endcase
        model_step();
        @(negedge clk);
        check_all(ph);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
